// File: rtl/alu_pkg.sv
// alu_pkg: op codes, status codes, FSM states and status priority helper shared by alu_seq and alu_mul_iter
package alu_pkg;
  typedef enum logic [2:0] {
    OP_SUB    = 3'b000,
    OP_LT     = 3'b001,
    OP_SETBIT = 3'b010,
    OP_SM2U2  = 3'b011,
    OP_MUL    = 3'b100
  } op_t;
  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_OVF  = 2'b01,
    ST_ZERO = 2'b10,
    ST_INV  = 2'b11
  } status_t;
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;
  function automatic status_t pick_status(input logic inv, input logic ovf, input logic zero);
    return inv ? ST_INV : ovf ? ST_OVF : zero ? ST_ZERO : ST_OK;
  endfunction
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle, m-cycle latency
// Ports: i_clk, i_rst (sync, active-high), i_start loads i_a/i_b, o_done pulses with the 2m-bit product on o_prod.
module alu_mul_iter #(
  parameter int m = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [m-1:0]   i_a,
  input  logic [m-1:0]   i_b,
  output logic           o_done,
  output logic [2*m-1:0] o_prod
);
  localparam int cw = $clog2(m + 1);
  logic [2*m-1:0] acc_q, acc_d, acc_src, step;
  logic [m-1:0] a_q, a_d, a_src;
  logic [cw-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, run;
  logic [m:0] sum;
  // The start cycle already folds in the first partial product, so the product is complete m edges after start.
  always_comb begin
    a_src = i_start ? i_a : a_q;
    acc_src = i_start ? {{m{1'b0}}, i_b} : acc_q;
    sum = {1'b0, acc_src[2*m-1:m]} + (acc_src[0] ? {1'b0, a_src} : {(m+1){1'b0}});
    step = {sum, acc_src[m-1:1]};
    run = i_start || (busy_q && cnt_q != '0);
    a_d = a_src;
    acc_d = run ? step : acc_q;
    cnt_d = i_start ? cw'(m - 1) : run ? cnt_q - cw'(1) : cnt_q;
    busy_d = run;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q <= '0;
      a_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      a_q <= a_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
  assign o_done = busy_q && cnt_q == '0;
  assign o_prod = acc_q;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential m-bit ALU (SUB, LT, SETBIT, SM2U2, optional MUL) with valid/ready on both sides
// Ports: i_clk, i_rst (sync, active-high); request i_valid/o_ready/i_op/i_argA/i_argB; response o_valid/i_ready/o_result/o_status.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier; otherwise op 100 is reported invalid.
module alu_seq
  import alu_pkg::*;
#(
  parameter int m = 4,
  parameter int n = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [2:0]   i_op,
  input  logic [m-1:0] i_argA,
  input  logic [m-1:0] i_argB,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [m-1:0] o_result,
  output logic [n-1:0] o_status
);
  localparam logic [m-1:0] m_idx = m[m-1:0];
  localparam logic [m-1:0] one = {{(m-1){1'b0}}, 1'b1};
  state_t state_q, state_d;
  status_t status_q, status_d;
  logic [m-1:0] result_q, result_d;
  logic [m+1:0] fn_out;
  // Returns {status, result} for every op that completes in one cycle; anything else is invalid.
  function automatic logic [m+1:0] alu_fn(input logic [2:0] op, input logic [m-1:0] a, input logic [m-1:0] b);
    logic [m-1:0] r;
    logic inv, ovf;
    r = '0;
    inv = 1'b0;
    ovf = 1'b0;
    case (op)
      OP_SUB: begin
        r = a - b;
        ovf = (a[m-1] ^ b[m-1]) & (r[m-1] ^ a[m-1]);
      end
      OP_LT: r = {{(m-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SETBIT: begin
        inv = b >= m_idx;
        r = inv ? '0 : a | (one << b);
      end
      OP_SM2U2: r = a[m-1] ? -{1'b0, a[m-2:0]} : a;
      default: inv = 1'b1;
    endcase
    return {pick_status(inv, ovf, r == '0), r};
  endfunction
`ifdef ALU_SEQ_MUL_EN
  logic mul_start, mul_done;
  logic [2*m-1:0] mul_prod;
  assign mul_start = state_q == IDLE && i_valid && i_op == OP_MUL;
  alu_mul_iter #(.m(m)) u_mul (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(mul_start),
    .i_a    (i_argA),
    .i_b    (i_argB),
    .o_done (mul_done),
    .o_prod (mul_prod)
  );
`endif
  always_comb begin
    fn_out = alu_fn(i_op, i_argA, i_argB);
    state_d = state_q;
    result_d = result_q;
    status_d = status_q;
    if (state_q == IDLE && i_valid) begin
      state_d = DONE;
      result_d = fn_out[m-1:0];
      status_d = status_t'(fn_out[m+1:m]);
`ifdef ALU_SEQ_MUL_EN
      if (i_op == OP_MUL) state_d = BUSY;
`endif
    end
`ifdef ALU_SEQ_MUL_EN
    if (state_q == BUSY && mul_done) begin
      state_d = DONE;
      result_d = mul_prod[m-1:0];
      status_d = pick_status(1'b0, |mul_prod[2*m-1:m], mul_prod[m-1:0] == '0);
    end
`endif
    if (state_q == DONE && i_ready) state_d = IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      result_q <= '0;
      status_q <= ST_OK;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end
  assign o_ready = state_q == IDLE;
  assign o_valid = state_q == DONE;
  assign o_result = result_q;
  assign o_status = n'(status_q);
endmodule
